// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bus for serial_sub.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock over WIDTH SHIFT cycles.
// Optional SERIAL_SUB_OVF_EN: registered two's-complement overflow flag.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bor;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;

    logic             w_x;
    logic             w_y;
    logic             w_d1;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Two cascaded half subtractors: (x - y), then (d1 - borrow_in).
    assign w_x        = r_a_sr[0];
    assign w_y        = r_b_sr[0];
    assign w_d1       = w_x ^ w_y;
    assign w_d        = w_d1 ^ r_bor;
    assign w_bout     = (~w_x & w_y) | (~w_d1 & r_bor);
    assign w_res_next = WIDTH'({w_d, r_res} >> 1);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
    assign bus.ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_bor   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_bor   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_res  <= w_res_next;
                    r_bor  <= w_bout;
                    r_cnt  <= r_cnt + CW'(1);
                    // Results are published only here so partial sums never leak out.
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_res_next;
                        r_bout  <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_bout;
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial subtractor that computes diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first. The bit cell is two cascaded half subtractors (d = x^y, b = ~x&y) plus a registered borrow flip-flop. It sits directly downstream of the operand source and replaces a WIDTH-wide ripple subtractor where area matters more than latency. It has a start/busy/done handshake toward the controlling block.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  1 when a < b (unsigned)

Behaviour:
- Reset: all outputs 0 on the first rising clk edge with rst=1. State = IDLE, shift registers = 0, borrow flop = 0, bit counter = 0.
- States:
  - IDLE: waiting for start.
  - SHIFT: processing bits.
  - DONE: one cycle, presenting the result.
- Acceptance: an edge with start=1 and busy=0 (state IDLE or DONE) loads a and b into shift registers, clears the borrow flop and counter, and moves to SHIFT.
- start while busy=1 is ignored. a and b are don't-care outside the accepting edge.
- SHIFT, per edge:
  - Take x = a_sr[0], y = b_sr[0], bin = borrow flop.
  - Compute d = x^y^bin and bout = (~x&y) | (~(x^y)&bin).
  - Shift d into the MSB of the result register, shifting right. Right-shift a_sr and b_sr. Store bout in the borrow flop. Increment the counter.
  - After WIDTH SHIFT edges, go to DONE.
- busy = 1 exactly in SHIFT, i.e. for WIDTH cycles starting the cycle after acceptance.
- DONE: done = 1 for exactly one cycle, the cycle after the last SHIFT cycle.
  - diff holds the full result.
  - borrow_out = final borrow flop.
  - Next state is IDLE, or SHIFT if start=1.
- Latency: done goes high WIDTH+1 cycles after the accepting edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- diff and borrow_out are registered and update only on the transition into DONE. They hold until the next transition into DONE, so partial results are never visible. They are also cleared by reset.
- Reset mid-operation (rst=1 in SHIFT): the operation is abandoned, outputs are cleared, no done pulse is produced, and the next state is IDLE.
- rst has priority over start on the same edge.
- WIDTH=1: a single SHIFT cycle; diff = a^b, borrow_out = ~a&b.
- Counter width is clog2(WIDTH+1) bits. The counter must not wrap before reaching WIDTH.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - Set in DONE when the signed (two's-complement) subtraction overflowed: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - Registered alongside diff, reset to 0, held like diff.
  - The MSBs of a and b are captured at acceptance.
- Undefined: no ovf port and no associated flops; all other behaviour is identical.

Test Plan:
1. WIDTH=8, rst 2 cycles then release -> busy=0, done=0, diff=8'h00, borrow_out=0. Then a=8'd5, b=8'd3, start 1 cycle -> busy high 8 cycles, done pulse on cycle 9 after acceptance, diff=8'h02, borrow_out=0.
2. a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1. Also a=8'h00, b=8'h00 -> diff=8'h00, borrow_out=0.
3. a=8'hFF, b=8'h00 -> diff=8'hFF, borrow_out=0. Then a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1, checking the borrow chain through all bits.
4. Hold start=1 continuously with new operands each accept (10-2, then 2-10) -> start ignored while busy. Results 8'h08/0 then 8'hF8/1, done pulses exactly 9 cycles apart, diff stable between pulses.
5. Accept 8'hAA - 8'h55, assert rst on SHIFT cycle 4 -> no done pulse, diff=0, borrow_out=0, busy=0 next cycle. A fresh start then completes normally (8'hAA - 8'h55 = 8'h55, borrow_out=0).
6. SERIAL_SUB_OVF_EN defined:
   - 8'h80 - 8'h01 -> diff=8'h7F, ovf=1.
   - 8'h05 - 8'h03 -> ovf=0.
   - 8'h7F - 8'hFF -> diff=8'h80, ovf=1.
